i8008_bus_ctrl: RTL and testbench
=================================

// Module: i8008_bus_ctrl
// PURPOSE
//  External bus sequencer for i8008_core: decodes core state/D_out into memory and I/O transfers.
//  Drives READY with wait-state insertion, returns read data on D_in, and issues writes.
//  Injects interrupts by jamming an RST opcode during the T1I fetch.
//  Sits between i8008_core and the system SRAM and I/O ports.
// PARAMETERS
//  WAIT_STATES  0     extra cycles READY stays low after the address phase (0..15)
//  IRQ_VECTOR   3'd0  AAA field of the jammed RST opcode 00_AAA_101
//  IO_IN_PORTS  8     PCC ports below this number are inputs; the rest are outputs
// PORTS
//  clk        in   1   clock
//  rst        in   1   asynchronous, active-high reset
//  state      in   3   core state_t (T1,T1I,T2,WAIT,T3,STOPPED,T4,T5)
//  D_out      in   8   core bus out
//  D_in       out  8   core bus in; equals din_q
//  READY      out  1   transfer may complete (combinational from flops only)
//  INTR       out  1   interrupt request to core
//  mem_addr   out  14  memory address
//  mem_re     out  1   SRAM read strobe; rdata valid the following cycle
//  mem_rdata  in   8   SRAM read data
//  mem_we     out  1   SRAM write strobe
//  mem_wdata  out  8   SRAM write data
//  io_port    out  5   I/O port number
//  io_rd      out  1   input-port strobe; io_rdata valid in the same cycle
//  io_rdata   in   8   input-port data
//  io_wr      out  1   output-port strobe
//  io_wdata   out  8   output-port data
//  ext_irq    in   1   external interrupt; acted on at the rising edge
//  irq_ack    out  1   1-cycle pulse when the core enters T1I
// BEHAVIOUR
//  Reset: all outputs 0; cst=C_IDLE; din_q, rd_ok, cnt, jam, irq_q cleared; async reset mid-transfer aborts it, no strobes.
//  Cycle types use cycle_ctrl_t at T2: D_out[7:6] PCI=00, PCR=01, PCC=10, PCW=11.
//  FSM cst (edge actions use the state value sampled at that edge):
//   C_IDLE -> C_LO on state∈{T1,T1I}: addr_lo_q<=D_out (PCC: also io_wdata<=D_out).
//   C_LO -> C_XFER on state==T2: addr_hi_q<=D_out[5:0], type_q<=D_out[7:6], cnt<=WAIT_STATES.
//   C_XFER: cnt decrements to 0 and holds; -> C_IDLE on state==T3 (rd_ok, jam cleared).
//   state∈{T1,T1I} in any cst restarts the cycle (re-latch, cst=C_LO); T2 seen in C_IDLE is ignored.
//  mem_addr = {D_out[5:0],addr_lo_q} while cst==C_LO && state==T2; else {addr_hi_q,addr_lo_q}.
//  Memory read (PCI/PCR, no jam): mem_re=1 during the T2 cycle; the next edge sets rd_pend.
//   The edge after that does din_q<=mem_rdata, rd_ok<=1.
//  Input (PCC, D_out[5:1]<IO_IN_PORTS): io_port=D_out[5:1], io_rd=1 during the T2 cycle.
//   The same edge does din_q<=io_rdata, rd_ok<=1.
//  Write (PCW): mem_we=1, mem_wdata=D_out while cst==C_XFER && state==T3.
//  Output (PCC, port>=IO_IN_PORTS): io_wr=1 during T3; io_port=latched port; io_wdata from the T1 latch.
//  READY = cst==C_XFER && cnt==0 && (rd_ok || write/output cycle). READY is never high in T2, so there is at least 1 WAIT.
//   With WAIT_STATES=0: memory read 2 WAIT, write/I/O 1 WAIT. With N>0: ready no earlier than N cycles after entering C_XFER.
//  Interrupt: irq_q tracks ext_irq; rising edge sets INTR; state==T1I clears INTR, pulses irq_ack, sets jam.
//   A jam fetch issues no mem_re: din_q<={2'b00,IRQ_VECTOR,3'b101} and rd_ok<=1 at the T2 edge.
//   A new rising edge in the same cycle as T1I keeps INTR=1 (set wins); the request depth is one.
//  STOPPED/T4/T5: no strobes; INTR still set by ext_irq, so the core can wake from halt.
// TESTING
//  rst=1 asserted during a read WAIT -> READY, mem_re, INTR, D_in all 0 immediately; first cycle after release is clean.
//  PCI fetch: T1 D_out=0x05, T2 D_out=0x01, mem_rdata=0xC8 -> mem_re in T2 with mem_addr=0x0105; 2 WAIT; D_in=0xC8 in T3.
//  PCW: T1 0x10, T2 0xC2, T3 D_out=0x5A -> 1 WAIT; mem_we for exactly 1 cycle, mem_addr=0x0210, mem_wdata=0x5A.
//  WAIT_STATES=3 PCR -> READY rises 3 cycles after entering C_XFER; the core sits in WAIT 3 cycles; mem_re only once.
//  PCC port 10 with T1 A=0x77 -> io_wr in T3, io_wdata=0x77; port 3 with io_rdata=0x9C -> io_rd in T2, D_in=0x9C.
//  IRQ_VECTOR=7, ext_irq 0->1 -> INTR=1 next cycle; on T1I: INTR=0, irq_ack pulse, no mem_re; D_in=0x3D in T3.

Source files
------------

// File: rtl/i8008_bus_ctrl.sv
// External bus sequencer for i8008_core: memory/I/O transfer decode, READY wait-state
// generation, read-data return on D_in and interrupt injection by jamming an RST opcode.
module i8008_bus_ctrl #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [2:0]  IRQ_VECTOR  = 3'd0,
    parameter int unsigned IO_IN_PORTS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic [7:0]  D_out,
    output logic [7:0]  D_in,
    output logic        READY,
    output logic        INTR,
    output logic [13:0] mem_addr,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic [4:0]  io_port,
    output logic        io_rd,
    input  logic [7:0]  io_rdata,
    output logic        io_wr,
    output logic [7:0]  io_wdata,
    input  logic        ext_irq,
    output logic        irq_ack
);

    typedef enum logic [2:0] {
        S_T1      = 3'd0,
        S_T1I     = 3'd1,
        S_T2      = 3'd2,
        S_WAIT    = 3'd3,
        S_T3      = 3'd4,
        S_STOPPED = 3'd5,
        S_T4      = 3'd6,
        S_T5      = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PCI = 2'b00,
        PCR = 2'b01,
        PCC = 2'b10,
        PCW = 2'b11
    } cycle_ctrl_t;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_LO   = 2'd1,
        C_XFER = 2'd2
    } cst_t;

    localparam logic [5:0] IN_LIMIT = 6'(IO_IN_PORTS);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);
    localparam logic [7:0] RST_OPCODE = {2'b00, IRQ_VECTOR, 3'b101};

    cst_t        cst_q;
    cycle_ctrl_t type_q;
    logic [7:0]  addr_lo_q;
    logic [5:0]  addr_hi_q;
    logic [3:0]  cnt_q;
    logic [7:0]  din_q;
    logic [7:0]  io_wdata_q;
    logic        rd_ok_q;
    logic        rd_pend_q;
    logic        jam_q;
    logic        irq_q;
    logic        intr_q;
    logic        irq_ack_q;

    state_t      st;
    cycle_ctrl_t t2_type;
    logic        t1_any;
    logic        lo_t2;
    logic        xfer_t3;
    logic        t2_in_port;
    logic        xfer_out_port;
    logic        irq_rise;

    assign st            = state_t'(state);
    assign t2_type       = cycle_ctrl_t'(D_out[7:6]);
    assign t1_any        = (st == S_T1) || (st == S_T1I);
    assign lo_t2         = (cst_q == C_LO) && (st == S_T2);
    assign xfer_t3       = (cst_q == C_XFER) && (st == S_T3);
    assign t2_in_port    = {1'b0, D_out[5:1]} < IN_LIMIT;
    assign xfer_out_port = {1'b0, addr_hi_q[5:1]} >= IN_LIMIT;
    assign irq_rise      = ext_irq && !irq_q;

    assign D_in     = din_q;
    assign INTR     = intr_q;
    assign irq_ack  = irq_ack_q;
    assign io_wdata = io_wdata_q;

    // Strobes follow the live core state so they line up with T2/T3 exactly.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        mem_addr  = {addr_hi_q, addr_lo_q};
        io_port   = addr_hi_q[5:1];
        mem_re    = 1'b0;
        io_rd     = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        io_wr     = 1'b0;
        READY     = 1'b0;

        if (lo_t2) begin
            mem_addr = {D_out[5:0], addr_lo_q};
            io_port  = D_out[5:1];
            mem_re   = ((t2_type == PCI) || (t2_type == PCR)) && !jam_q;
            io_rd    = (t2_type == PCC) && t2_in_port;
        end

        if (xfer_t3) begin
            mem_we = (type_q == PCW);
            io_wr  = (type_q == PCC) && xfer_out_port;
        end
        if (mem_we) begin
            mem_wdata = D_out;
        end

        if ((cst_q == C_XFER) && (cnt_q == '0)) begin
            READY = rd_ok_q || (type_q == PCW) || ((type_q == PCC) && xfer_out_port);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cst_q      <= C_IDLE;
            type_q     <= PCI;
            addr_lo_q  <= '0;
            addr_hi_q  <= '0;
            cnt_q      <= '0;
            din_q      <= '0;
            io_wdata_q <= '0;
            rd_ok_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            jam_q      <= 1'b0;
            irq_q      <= 1'b0;
            intr_q     <= 1'b0;
            irq_ack_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees pre-edge values.
            irq_q     <= ext_irq;
            irq_ack_q <= (st == S_T1I);

            // A rising edge in the same cycle as T1I wins over the clear.
            if (irq_rise) begin
                intr_q <= 1'b1;
            end else if (st == S_T1I) begin
                intr_q <= 1'b0;
            end

            if (t1_any) begin
                cst_q     <= C_LO;
                addr_lo_q <= D_out;
                jam_q     <= (st == S_T1I);
                rd_ok_q   <= 1'b0;
                rd_pend_q <= 1'b0;
            end else begin
                case (cst_q)
                    C_LO: begin
                        if (st == S_T2) begin
                            cst_q     <= C_XFER;
                            addr_hi_q <= D_out[5:0];
                            type_q    <= t2_type;
                            cnt_q     <= CNT_INIT;
                            if (jam_q) begin
                                din_q   <= RST_OPCODE;
                                rd_ok_q <= 1'b1;
                            end else if ((t2_type == PCI) || (t2_type == PCR)) begin
                                rd_pend_q <= 1'b1;
                            end else if (t2_type == PCC) begin
                                io_wdata_q <= addr_lo_q;
                                if (t2_in_port) begin
                                    din_q   <= io_rdata;
                                    rd_ok_q <= 1'b1;
                                end
                            end
                        end
                    end
                    C_XFER: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                        // SRAM data is valid the cycle after the T2 read strobe.
                        if (rd_pend_q) begin
                            din_q     <= mem_rdata;
                            rd_ok_q   <= 1'b1;
                            rd_pend_q <= 1'b0;
                        end
                        if (st == S_T3) begin
                            cst_q     <= C_IDLE;
                            rd_ok_q   <= 1'b0;
                            rd_pend_q <= 1'b0;
                            jam_q     <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i8008_bus_ctrl.sv
// Bench for i8008_bus_ctrl: a small core-side sequencer drives bus cycles into two
// instances (0 wait states / vector 0, and 3 wait states / vector 7) with a data scoreboard.
module tb_i8008_bus_ctrl;

    localparam logic [2:0] T1 = 3'd0, T1I = 3'd1, T2 = 3'd2, TW = 3'd3;
    localparam logic [2:0] T3 = 3'd4, STOP = 3'd5, T4 = 3'd6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state = T4;
    logic [7:0] d_out = 8'h00;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] io_rdata = 8'h00;
    logic       ext_irq = 1'b0;
    logic       sel = 1'b0;

    logic [7:0]  d_in0, d_in1, mem_wdata0, mem_wdata1, io_wdata0, io_wdata1;
    logic [13:0] mem_addr0, mem_addr1;
    logic [4:0]  io_port0, io_port1;
    logic ready0, ready1, intr0, intr1, mem_re0, mem_re1, mem_we0, mem_we1;
    logic io_rd0, io_rd1, io_wr0, io_wr1, irq_ack0, irq_ack1;

    i8008_bus_ctrl u_dut0 (
        .clk(clk), .rst(rst), .state(state), .D_out(d_out), .D_in(d_in0), .READY(ready0),
        .INTR(intr0), .mem_addr(mem_addr0), .mem_re(mem_re0), .mem_rdata(mem_rdata),
        .mem_we(mem_we0), .mem_wdata(mem_wdata0), .io_port(io_port0), .io_rd(io_rd0),
        .io_rdata(io_rdata), .io_wr(io_wr0), .io_wdata(io_wdata0), .ext_irq(ext_irq),
        .irq_ack(irq_ack0)
    );

    i8008_bus_ctrl #(.WAIT_STATES(3), .IRQ_VECTOR(3'd7), .IO_IN_PORTS(8)) u_dut1 (
        .clk(clk), .rst(rst), .state(state), .D_out(d_out), .D_in(d_in1), .READY(ready1),
        .INTR(intr1), .mem_addr(mem_addr1), .mem_re(mem_re1), .mem_rdata(mem_rdata),
        .mem_we(mem_we1), .mem_wdata(mem_wdata1), .io_port(io_port1), .io_rd(io_rd1),
        .io_rdata(io_rdata), .io_wr(io_wr1), .io_wdata(io_wdata1), .ext_irq(ext_irq),
        .irq_ack(irq_ack1)
    );

    logic [7:0]  o_d_in, o_mem_wdata, o_io_wdata;
    logic [13:0] o_mem_addr;
    logic [4:0]  o_io_port;
    logic o_ready, o_intr, o_mem_re, o_mem_we, o_io_rd, o_io_wr, o_irq_ack;

    assign o_d_in      = sel ? d_in1 : d_in0;
    assign o_mem_wdata = sel ? mem_wdata1 : mem_wdata0;
    assign o_io_wdata  = sel ? io_wdata1 : io_wdata0;
    assign o_mem_addr  = sel ? mem_addr1 : mem_addr0;
    assign o_io_port   = sel ? io_port1 : io_port0;
    assign o_ready     = sel ? ready1 : ready0;
    assign o_intr      = sel ? intr1 : intr0;
    assign o_mem_re    = sel ? mem_re1 : mem_re0;
    assign o_mem_we    = sel ? mem_we1 : mem_we0;
    assign o_io_rd     = sel ? io_rd1 : io_rd0;
    assign o_io_wr     = sel ? io_wr1 : io_wr0;
    assign o_irq_ack   = sel ? irq_ack1 : irq_ack0;

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // kind: 0 = D_in at T3, 1 = mem_wdata at T3, 2 = io_wdata at T3
    typedef struct {
        string      name;
        int         kind;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    logic        t1_intr, t2_re, t2_iord, t2_ready, t2_intr, t2_ack, t3_we, t3_iowr;
    logic [13:0] t2_addr, t3_addr;
    logic [4:0]  t2_port, t3_port;
    int waits, ready_idx, re_cnt, we_cnt, iord_cnt, iowr_cnt, ack_cnt;

    task automatic push_exp(input string name, input int kind, input logic [7:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    // NOTE: stimulus changes at the falling edge with blocking writes; outputs are read 1 unit later.
    task automatic drive(input logic [2:0] st, input logic [7:0] d);
        @(negedge clk);
        state = st;
        d_out = d;
        #1;
    endtask

    task automatic tally;
        re_cnt   += int'(o_mem_re);
        we_cnt   += int'(o_mem_we);
        iord_cnt += int'(o_io_rd);
        iowr_cnt += int'(o_io_wr);
        ack_cnt  += int'(o_irq_ack);
    endtask

    task automatic bus_cycle(input logic [2:0] t1_state, input logic [7:0] lo, input logic [7:0] hi,
                             input logic [7:0] t3_byte, input logic [7:0] rdata,
                             input logic [7:0] iodata, input bit irq_at_t1);
        exp_t e;
        logic [7:0] obs;
        re_cnt = 0; we_cnt = 0; iord_cnt = 0; iowr_cnt = 0; ack_cnt = 0;

        drive(t1_state, lo);
        if (irq_at_t1) ext_irq = 1'b1;
        t1_intr = o_intr;
        tally();

        drive(T2, hi);
        mem_rdata = 8'hEE;
        io_rdata  = iodata;
        #1;
        t2_re = o_mem_re; t2_addr = o_mem_addr; t2_iord = o_io_rd; t2_port = o_io_port;
        t2_ready = o_ready; t2_intr = o_intr; t2_ack = o_irq_ack;
        tally();

        waits = 0;
        ready_idx = -1;
        while (ready_idx < 0 && waits < 40) begin
            drive(TW, 8'h00);
            mem_rdata = (waits == 0) ? rdata : 8'h11;
            io_rdata  = 8'h22;
            tally();
            if (o_ready) ready_idx = waits;
            waits++;
        end
        total++;
        if (ready_idx < 0) begin
            bad++;
            $display("FAIL ready_timeout: READY still low after %0d WAIT cycles, want high", waits);
        end

        drive(T3, t3_byte);
        t3_we = o_mem_we; t3_addr = o_mem_addr; t3_iowr = o_io_wr; t3_port = o_io_port;
        tally();
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: DUT completed a transfer with no expected result queued");
        end else begin
            e = sb.pop_front();
            case (e.kind)
                0:       obs = o_d_in;
                1:       obs = o_mem_wdata;
                default: obs = o_io_wdata;
            endcase
            if (obs !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end

        drive(T4, 8'h00);
        tally();
    endtask

    task automatic test_reset;
        sel = 1'b0;
        rst = 1'b1;
        state = T2;
        d_out = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", o_ready); end
        total++; if (o_mem_re !== 1'b0) begin bad++; $display("FAIL rst_mem_re: got %b want 0", o_mem_re); end
        total++; if (o_intr !== 1'b0) begin bad++; $display("FAIL rst_intr: got %b want 0", o_intr); end
        total++; if (o_d_in !== 8'h00) begin bad++; $display("FAIL rst_d_in: got %h want 00", o_d_in); end
        total++; if (o_mem_addr !== 14'h0000) begin bad++; $display("FAIL rst_mem_addr: got %h want 0000", o_mem_addr); end
        total++;
        if ({o_mem_we, o_io_wr, o_io_rd, o_irq_ack, o_io_port, o_io_wdata, o_mem_wdata} !== '0) begin
            bad++;
            $display("FAIL rst_others: we=%b wr=%b rd=%b ack=%b port=%h iow=%h mw=%h want all 0",
                     o_mem_we, o_io_wr, o_io_rd, o_irq_ack, o_io_port, o_io_wdata, o_mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        state = T4;
        d_out = 8'h00;
    endtask

    task automatic test_pci;
        sel = 1'b0;
        push_exp("pci_d_in", 0, 8'hC8);
        bus_cycle(T1, 8'h05, 8'h01, 8'h00, 8'hC8, 8'h00, 1'b0);
        total++; if (t2_re !== 1'b1) begin bad++; $display("FAIL pci_re_t2: got %b want 1", t2_re); end
        total++; if (t2_addr !== 14'h0105) begin bad++; $display("FAIL pci_addr: got %h want 0105", t2_addr); end
        total++; if (t2_ready !== 1'b0) begin bad++; $display("FAIL pci_ready_t2: got %b want 0", t2_ready); end
        total++; if (waits != 2) begin bad++; $display("FAIL pci_waits: got %0d want 2", waits); end
        total++; if (re_cnt != 1) begin bad++; $display("FAIL pci_re_count: got %0d want 1", re_cnt); end
    endtask

    task automatic test_pcw;
        sel = 1'b0;
        push_exp("pcw_wdata", 1, 8'h5A);
        bus_cycle(T1, 8'h10, 8'hC2, 8'h5A, 8'h00, 8'h00, 1'b0);
        total++; if (waits != 1) begin bad++; $display("FAIL pcw_waits: got %0d want 1", waits); end
        total++; if (t3_we !== 1'b1) begin bad++; $display("FAIL pcw_we_t3: got %b want 1", t3_we); end
        total++; if (we_cnt != 1) begin bad++; $display("FAIL pcw_we_count: got %0d want 1", we_cnt); end
        total++; if (t3_addr !== 14'h0210) begin bad++; $display("FAIL pcw_addr: got %h want 0210", t3_addr); end
        total++; if (re_cnt != 0) begin bad++; $display("FAIL pcw_no_re: got %0d want 0", re_cnt); end
    endtask

    task automatic test_io;
        sel = 1'b0;
        // Output port 10, data from the T1 latch; D_out in T3 is deliberately different.
        push_exp("out10_wdata", 2, 8'h77);
        bus_cycle(T1, 8'h77, 8'h94, 8'h00, 8'h00, 8'h00, 1'b0);
        total++; if (iowr_cnt != 1 || t3_iowr !== 1'b1) begin bad++; $display("FAIL out10_wr: got count %0d t3 %b want 1 1", iowr_cnt, t3_iowr); end
        total++; if (t3_port !== 5'd10) begin bad++; $display("FAIL out10_port: got %0d want 10", t3_port); end
        total++; if (waits != 1) begin bad++; $display("FAIL out10_waits: got %0d want 1", waits); end
        total++; if (iord_cnt != 0 || re_cnt != 0) begin bad++; $display("FAIL out10_no_rd: got io_rd %0d mem_re %0d want 0 0", iord_cnt, re_cnt); end

        push_exp("in3_d_in", 0, 8'h9C);
        bus_cycle(T1, 8'h21, 8'h86, 8'h00, 8'h00, 8'h9C, 1'b0);
        total++; if (t2_iord !== 1'b1) begin bad++; $display("FAIL in3_rd_t2: got %b want 1", t2_iord); end
        total++; if (t2_port !== 5'd3) begin bad++; $display("FAIL in3_port: got %0d want 3", t2_port); end
        total++; if (iord_cnt != 1 || iowr_cnt != 0) begin bad++; $display("FAIL in3_strobes: got rd %0d wr %0d want 1 0", iord_cnt, iowr_cnt); end
        total++; if (waits != 1) begin bad++; $display("FAIL in3_waits: got %0d want 1", waits); end

        // Boundary ports: 7 is the last input, 8 the first output.
        push_exp("in7_d_in", 0, 8'h42);
        bus_cycle(T1, 8'h00, 8'h8E, 8'h00, 8'h00, 8'h42, 1'b0);
        total++; if (iord_cnt != 1 || iowr_cnt != 0) begin bad++; $display("FAIL in7_strobes: got rd %0d wr %0d want 1 0", iord_cnt, iowr_cnt); end
        push_exp("out8_wdata", 2, 8'hA5);
        bus_cycle(T1, 8'hA5, 8'h90, 8'h00, 8'h00, 8'h00, 1'b0);
        total++; if (iowr_cnt != 1 || iord_cnt != 0) begin bad++; $display("FAIL out8_strobes: got wr %0d rd %0d want 1 0", iowr_cnt, iord_cnt); end
    endtask

    task automatic test_wait_states;
        sel = 1'b1;
        push_exp("ws3_d_in", 0, 8'h3C);
        bus_cycle(T1, 8'h99, 8'h43, 8'h00, 8'h3C, 8'h00, 1'b0);
        total++; if (ready_idx != 3) begin bad++; $display("FAIL ws3_read_ready_idx: got %0d want 3", ready_idx); end
        total++; if (re_cnt != 1) begin bad++; $display("FAIL ws3_re_count: got %0d want 1", re_cnt); end
        total++; if (t2_addr !== 14'h0399) begin bad++; $display("FAIL ws3_addr: got %h want 0399", t2_addr); end
        push_exp("ws3_wdata", 1, 8'h66);
        bus_cycle(T1, 8'h00, 8'hC0, 8'h66, 8'h00, 8'h00, 1'b0);
        total++; if (ready_idx != 3) begin bad++; $display("FAIL ws3_write_ready_idx: got %0d want 3", ready_idx); end
        total++; if (we_cnt != 1) begin bad++; $display("FAIL ws3_we_count: got %0d want 1", we_cnt); end
    endtask

    task automatic test_irq;
        sel = 1'b1;
        drive(T4, 8'h00);
        ext_irq = 1'b0;
        drive(T4, 8'h00);
        drive(STOP, 8'h00);
        ext_irq = 1'b1;
        #1;
        total++; if (o_intr !== 1'b0) begin bad++; $display("FAIL irq_intr_early: got %b want 0", o_intr); end
        drive(STOP, 8'h00);
        total++; if (o_intr !== 1'b1) begin bad++; $display("FAIL irq_intr_set: got %b want 1", o_intr); end
        total++;
        if ({o_mem_re, o_mem_we, o_io_rd, o_io_wr, o_ready} !== '0) begin
            bad++;
            $display("FAIL stopped_strobes: got re=%b we=%b rd=%b wr=%b rdy=%b want all 0",
                     o_mem_re, o_mem_we, o_io_rd, o_io_wr, o_ready);
        end

        push_exp("irq_jam_d_in", 0, 8'h3D);
        bus_cycle(T1I, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 1'b0);
        total++; if (t1_intr !== 1'b1) begin bad++; $display("FAIL irq_intr_in_t1i: got %b want 1", t1_intr); end
        total++; if (t2_intr !== 1'b0) begin bad++; $display("FAIL irq_intr_clear: got %b want 0", t2_intr); end
        total++; if (t2_ack !== 1'b1 || ack_cnt != 1) begin bad++; $display("FAIL irq_ack_pulse: got t2 %b count %0d want 1 1", t2_ack, ack_cnt); end
        total++; if (re_cnt != 0) begin bad++; $display("FAIL irq_no_re: got %0d want 0", re_cnt); end
        total++; if (d_in0 !== 8'h05) begin bad++; $display("FAIL irq_vec0_d_in: got %h want 05", d_in0); end

        // A fresh rising edge during T1I keeps the request pending.
        drive(T4, 8'h00);
        ext_irq = 1'b0;
        drive(T4, 8'h00);
        push_exp("irq_jam2_d_in", 0, 8'h3D);
        bus_cycle(T1I, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 1'b1);
        total++; if (t2_intr !== 1'b1) begin bad++; $display("FAIL irq_set_wins: got %b want 1", t2_intr); end
        total++; if (ack_cnt != 1) begin bad++; $display("FAIL irq_ack2_count: got %0d want 1", ack_cnt); end
    endtask

    task automatic test_back_to_back;
        sel = 1'b0;
        push_exp("b2b_a_d_in", 0, 8'h3A);
        push_exp("b2b_b_d_in", 0, 8'hB7);
        drive(T1, 8'h33);
        bus_cycle(T1, 8'h44, 8'h00, 8'h00, 8'h3A, 8'h00, 1'b0);
        total++; if (t2_addr !== 14'h0044) begin bad++; $display("FAIL b2b_restart_addr: got %h want 0044", t2_addr); end
        total++; if (waits != 2) begin bad++; $display("FAIL b2b_a_waits: got %0d want 2", waits); end
        bus_cycle(T1, 8'h80, 8'h7F, 8'h00, 8'hB7, 8'h00, 1'b0);
        total++; if (t2_addr !== 14'h3F80) begin bad++; $display("FAIL b2b_b_addr: got %h want 3f80", t2_addr); end
        total++; if (re_cnt != 1) begin bad++; $display("FAIL b2b_b_re_count: got %0d want 1", re_cnt); end
        drive(T2, 8'h01);
        total++; if (o_mem_re !== 1'b0 || o_io_rd !== 1'b0) begin bad++; $display("FAIL idle_t2_strobe: got re %b rd %b want 0 0", o_mem_re, o_io_rd); end
        drive(TW, 8'h00);
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL idle_t2_ready: got %b want 0", o_ready); end
        drive(T4, 8'h00);
    endtask

    task automatic test_reset_mid;
        sel = 1'b0;
        drive(T4, 8'h00);
        ext_irq = 1'b0;
        drive(T4, 8'h00);
        ext_irq = 1'b1;
        drive(T4, 8'h00);
        total++; if (o_intr !== 1'b1) begin bad++; $display("FAIL rm_intr_pre: got %b want 1", o_intr); end
        drive(T1, 8'h05);
        drive(T2, 8'h01);
        mem_rdata = 8'hEE;
        drive(TW, 8'h00);
        mem_rdata = 8'h77;
        drive(TW, 8'h00);
        total++; if (o_ready !== 1'b1 || o_d_in !== 8'h77) begin bad++; $display("FAIL rm_pre: got ready %b d_in %h want 1 77", o_ready, o_d_in); end
        rst = 1'b1;
        #1;
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL rm_ready: got %b want 0", o_ready); end
        total++; if (o_mem_re !== 1'b0) begin bad++; $display("FAIL rm_mem_re: got %b want 0", o_mem_re); end
        total++; if (o_intr !== 1'b0) begin bad++; $display("FAIL rm_intr: got %b want 0", o_intr); end
        total++; if (o_d_in !== 8'h00) begin bad++; $display("FAIL rm_d_in: got %h want 00", o_d_in); end
        ext_irq = 1'b0;
        drive(TW, 8'h00);
        rst = 1'b0;
        drive(T3, 8'h5A);
        total++;
        if ({o_mem_we, o_io_wr, o_ready, o_intr, o_d_in} !== '0) begin
            bad++;
            $display("FAIL rm_after_release: got we=%b wr=%b rdy=%b intr=%b d_in=%h want all 0",
                     o_mem_we, o_io_wr, o_ready, o_intr, o_d_in);
        end
        drive(T4, 8'h00);
        push_exp("rm_recover_d_in", 0, 8'hC8);
        bus_cycle(T1, 8'h05, 8'h01, 8'h00, 8'hC8, 8'h00, 1'b0);
        total++; if (waits != 2) begin bad++; $display("FAIL rm_recover_waits: got %0d want 2", waits); end
    endtask

    initial begin
        test_reset();
        test_pci();
        test_pcw();
        test_io();
        test_wait_states();
        test_irq();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d queued results want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
